// File: rtl/mvm_pkg.sv
// Shared state encoding and default sizes for the matrix-vector multiply block.
// Used by the sequencer, the datapath and the top-level wrapper.
package mvm_pkg;

    localparam int MAT_SCALE    = 4;
    localparam int INPUT_WIDTH  = 8;
    localparam int OUTPUT_WIDTH = 2 * INPUT_WIDTH + $clog2(MAT_SCALE);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_X,
        COMPUTE,
        CAPTURE,
        DRAIN,
        FINISH
    } seq_state_t;

endpackage

// File: rtl/mvm_wait_counter.sv
// Loadable down-counter that times the multiply/add-tree latency.
// Stops at zero; zero_o is a plain decode of the count register.
module mvm_wait_counter #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mvm_sequencer.sv
// Control FSM for the matrix-vector multiply datapath: load A, load x, wait,
// capture y, stream y out and pulse done. All outputs are registered.
module mvm_sequencer #(
    parameter int MAT_SCALE   = mvm_pkg::MAT_SCALE,
    parameter int COMPUTE_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic reuse_a_i,
    input  logic of_a_i,
    input  logic of_x_i,
    input  logic of_y_i,
    output logic en_a_o,
    output logic en_x_o,
    output logic en_y_o,
    output logic clr_addr_a_o,
    output logic clr_addr_x_o,
    output logic clr_addr_y_o,
    output logic busy_o,
    output logic out_valid_o,
    output logic done_o
);

    import mvm_pkg::*;

    localparam int CNT_W = $clog2(COMPUTE_LAT + 1);

    if (COMPUTE_LAT < 1 || MAT_SCALE < 1) begin : gBadParams
        $error("mvm_sequencer: COMPUTE_LAT and MAT_SCALE must be at least 1");
    end

    seq_state_t state_q, state_d;

    logic en_a_q, en_a_d;
    logic en_x_q, en_x_d;
    logic en_y_q, en_y_d;
    logic clr_addr_a_q, clr_addr_a_d;
    logic clr_addr_x_q, clr_addr_x_d;
    logic clr_addr_y_q, clr_addr_y_d;
    logic busy_q, busy_d;
    logic out_valid_q, out_valid_d;
    logic done_q, done_d;

    logic waitLoad;
    logic waitZero;

    // Counter is reloaded on the edge that enters COMPUTE, so it reads LAT-1 in the first COMPUTE cycle.
    assign waitLoad = (state_d == COMPUTE) && (state_q != COMPUTE);

    mvm_wait_counter #(
        .WIDTH(CNT_W)
    ) u_wait (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (waitLoad),
        .value_i(CNT_W'(COMPUTE_LAT - 1)),
        .zero_o (waitZero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            en_a_q       <= 1'b0;
            en_x_q       <= 1'b0;
            en_y_q       <= 1'b0;
            clr_addr_a_q <= 1'b1;
            clr_addr_x_q <= 1'b1;
            clr_addr_y_q <= 1'b1;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            en_a_q       <= en_a_d;
            en_x_q       <= en_x_d;
            en_y_q       <= en_y_d;
            clr_addr_a_q <= clr_addr_a_d;
            clr_addr_x_q <= clr_addr_x_d;
            clr_addr_y_q <= clr_addr_y_d;
            busy_q       <= busy_d;
            out_valid_q  <= out_valid_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = reuse_a_i ? LOAD_X : LOAD_A;
                end
            end
            LOAD_A:  if (of_a_i)   state_d = LOAD_X;
            LOAD_X:  if (of_x_i)   state_d = COMPUTE;
            COMPUTE: if (waitZero) state_d = CAPTURE;
            CAPTURE: state_d = DRAIN;
            DRAIN:   if (of_y_i)   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the next state so the registered value lines up with the state it belongs to.
    always_comb begin
        en_a_d       = (state_d == LOAD_A);
        en_x_d       = (state_d == LOAD_X);
        en_y_d       = (state_d == CAPTURE);
        clr_addr_a_d = (state_d != LOAD_A);
        clr_addr_x_d = (state_d != LOAD_X);
        clr_addr_y_d = (state_d != DRAIN);
        busy_d       = (state_d != IDLE);
        done_d       = (state_d == FINISH);
        out_valid_d  = (state_q == DRAIN);
    end

    assign en_a_o       = en_a_q;
    assign en_x_o       = en_x_q;
    assign en_y_o       = en_y_q;
    assign clr_addr_a_o = clr_addr_a_q;
    assign clr_addr_x_o = clr_addr_x_q;
    assign clr_addr_y_o = clr_addr_y_q;
    assign busy_o       = busy_q;
    assign out_valid_o  = out_valid_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_mvm_sequencer.sv
// Bench for mvm_sequencer: two instances (COMPUTE_LAT 1 and 4), each paired with a behavioural datapath.
// Expected per-cycle activity is queued up front and a negedge monitor pops and compares it.
module tb_mvm_sequencer;

    localparam logic [8:0] IDLE_FLAGS = 9'b000000111;

    typedef struct {
        int         cyc;
        logic [8:0] flags;
        logic       chk;
        logic [15:0] data;
    } evt_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] startV;
    logic       reuse;
    logic [7:0] srcA [16];
    logic [7:0] srcX [4];
    logic [15:0] expY [4];

    int cyc;
    int t0;
    int actDut;
    int total;
    int bad;
    evt_t expQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic enA, enX, enY, clrA, clrX, clrY, busy, ov, done;
        logic ofA, ofX, ofY;
        logic [3:0] addrA;
        logic [1:0] addrX, addrY;
        logic [7:0] memA [16];
        logic [7:0] memX [4];
        logic [15:0] sumY [4];
        logic [15:0] yReg [4];
        logic [15:0] dout;
        logic [7:0] dataIn;

        assign ofA    = (addrA == 4'd15);
        assign ofX    = (addrX == 2'd3);
        assign ofY    = (addrY == 2'd3);
        assign dataIn = enA ? srcA[addrA] : srcX[addrX];

        always_comb begin
            for (int i = 0; i < 4; i++) begin
                sumY[i] = '0;
                for (int j = 0; j < 4; j++) begin
                    sumY[i] = sumY[i] + 16'(memA[i*4+j]) * 16'(memX[j]);
                end
            end
        end

        always @(posedge clk) begin
            addrA <= clrA ? 4'd0 : addrA + 4'd1;
            addrX <= clrX ? 2'd0 : addrX + 2'd1;
            addrY <= clrY ? 2'd0 : addrY + 2'd1;
            if (enA) memA[addrA] <= dataIn;
            if (enX) memX[addrX] <= dataIn;
            if (enY) begin
                for (int i = 0; i < 4; i++) yReg[i] <= sumY[i];
            end
            dout <= yReg[addrY];
        end

        mvm_sequencer #(
            .MAT_SCALE  (4),
            .COMPUTE_LAT((g == 0) ? 1 : 4)
        ) dut (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .start_i     (startV[g]),
            .reuse_a_i   (reuse),
            .of_a_i      (ofA),
            .of_x_i      (ofX),
            .of_y_i      (ofY),
            .en_a_o      (enA),
            .en_x_o      (enX),
            .en_y_o      (enY),
            .clr_addr_a_o(clrA),
            .clr_addr_x_o(clrX),
            .clr_addr_y_o(clrY),
            .busy_o      (busy),
            .out_valid_o (ov),
            .done_o      (done)
        );
    end

    function automatic logic [8:0] getFlags(input int d);
        if (d == 1)
            return {g_dut[1].busy, g_dut[1].enA, g_dut[1].enX, g_dut[1].enY, g_dut[1].ov,
                    g_dut[1].done, g_dut[1].clrA, g_dut[1].clrX, g_dut[1].clrY};
        return {g_dut[0].busy, g_dut[0].enA, g_dut[0].enX, g_dut[0].enY, g_dut[0].ov,
                g_dut[0].done, g_dut[0].clrA, g_dut[0].clrX, g_dut[0].clrY};
    endfunction

    function automatic logic [15:0] getData(input int d);
        return (d == 1) ? g_dut[1].dout : g_dut[0].dout;
    endfunction

    // Any cycle that is not plain idle must match the next queued expectation.
    always @(negedge clk) begin : monitor
        logic [8:0] f;
        logic [15:0] dat;
        evt_t e;
        if (rst_n) begin
            f   = getFlags(actDut);
            dat = getData(actDut);
            if (f != IDLE_FLAGS) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected activity cycle=%0d flags=%b", cyc - t0, f);
                end else begin
                    e = expQ.pop_front();
                    if (e.cyc != cyc - t0 || e.flags != f || (e.chk && e.data !== dat)) begin
                        bad++;
                        $display("[TB] FAIL activity cycle got=%0d exp=%0d flags got=%b exp=%b data got=%0d exp=%0d",
                                 cyc - t0, e.cyc, f, e.flags, dat, e.data);
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Expected activity for one full operation, relative to the start-sampling edge.
    task automatic pushOp(input int off, input bit ru, input int lat);
        evt_t e;
        int base, eny, doneC;
        logic ea, ex, ey, vo, dn, cy;
        base  = ru ? 0 : 16;
        eny   = base + 4 + lat + 1;
        doneC = eny + 5;
        for (int c = 1; c <= doneC; c++) begin
            ea = !ru && (c <= 16);
            ex = (c > base) && (c <= base + 4);
            ey = (c == eny);
            vo = (c >= eny + 2) && (c <= eny + 5);
            dn = (c == doneC);
            cy = !((c > eny) && (c <= eny + 4));
            e.cyc   = c + off;
            e.flags = {1'b1, ea, ex, ey, vo, dn, !ea, !ex, cy};
            e.chk   = vo;
            e.data  = vo ? expY[c - eny - 2] : 16'd0;
            expQ.push_back(e);
        end
    endtask

    task automatic applyStimulus(input int d, input bit ru);
        @(posedge clk); #1;
        t0          = cyc;
        actDut      = d;
        reuse       = ru;
        startV[d]   = 1'b1;
        @(posedge clk); #1;
        startV      = 2'b00;
        reuse       = 1'b0;
    endtask

    task automatic waitRel(input int n);
        while (cyc - t0 < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic pulseStart(input int d, input int n);
        waitRel(n);
        startV[d] = 1'b1;
        @(posedge clk); #1;
        startV = 2'b00;
    endtask

    task automatic waitIdle(input int maxc);
        int k;
        logic [8:0] f;
        k = 0;
        f = getFlags(actDut);
        while (f[8] && k < maxc) begin
            @(posedge clk); #1;
            k++;
            f = getFlags(actDut);
        end
        total++;
        if (k >= maxc) begin
            bad++;
            $display("[TB] FAIL idle timeout got=busy exp=idle within %0d cycles", maxc);
        end
    endtask

    task automatic checkDrained(input string name);
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL %s pending events got=%0d exp=0", name, expQ.size());
        end
        expQ.delete();
    endtask

    task automatic setX(input logic [7:0] x0, x1, x2, x3);
        srcX[0] = x0; srcX[1] = x1; srcX[2] = x2; srcX[3] = x3;
    endtask

    task automatic setY(input logic [15:0] y0, y1, y2, y3);
        expY[0] = y0; expY[1] = y1; expY[2] = y2; expY[3] = y3;
    endtask

    initial begin
        evt_t e;
        logic [8:0] f;
        total  = 0;
        bad    = 0;
        t0     = 0;
        actDut = 0;
        rst_n  = 1'b0;
        startV = 2'b00;
        reuse  = 1'b0;
        for (int i = 0; i < 16; i++) srcA[i] = 8'(i + 1);
        setX(8'd1, 8'd2, 8'd3, 8'd4);
        setY(16'd30, 16'd70, 16'd110, 16'd150);

        #12;
        checkOutput("reset flags dut0", 32'(getFlags(0)), 32'(IDLE_FLAGS));
        checkOutput("reset flags dut1", 32'(getFlags(1)), 32'(IDLE_FLAGS));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of LOAD_A aborts without a done pulse.
        for (int c = 1; c <= 4; c++) begin
            e.cyc = c; e.flags = 9'b110000011; e.chk = 1'b0; e.data = 16'd0;
            expQ.push_back(e);
        end
        applyStimulus(0, 1'b0);
        waitRel(5);
        rst_n = 1'b0;
        #1;
        checkOutput("async reset flags", 32'(getFlags(0)), 32'(IDLE_FLAGS));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        f = getFlags(0);
        checkOutput("busy after release", 32'(f[8]), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        checkDrained("reset abort");

        // Full load, then reuse of the stored A with a new x.
        pushOp(0, 1'b0, 1);
        applyStimulus(0, 1'b0);
        waitIdle(100);
        repeat (3) @(posedge clk);
        #1;
        checkDrained("full op");

        setX(8'd4, 8'd3, 8'd2, 8'd1);
        setY(16'd20, 16'd60, 16'd100, 16'd140);
        pushOp(0, 1'b1, 1);
        applyStimulus(0, 1'b1);
        waitIdle(100);
        repeat (3) @(posedge clk);
        #1;
        checkDrained("reuse op");

        // Start pulses while busy, including during FINISH, are dropped.
        setX(8'd1, 8'd2, 8'd3, 8'd4);
        setY(16'd30, 16'd70, 16'd110, 16'd150);
        pushOp(0, 1'b0, 1);
        applyStimulus(0, 1'b0);
        pulseStart(0, 3);
        pulseStart(0, 10);
        pulseStart(0, 27);
        waitIdle(100);
        repeat (5) @(posedge clk);
        #1;
        checkDrained("busy start ignored");

        // Start held high re-triggers once back in IDLE.
        pushOp(0, 1'b0, 1);
        pushOp(28, 1'b0, 1);
        @(posedge clk); #1;
        t0        = cyc;
        actDut    = 0;
        startV[0] = 1'b1;
        waitRel(30);
        startV    = 2'b00;
        waitIdle(100);
        repeat (3) @(posedge clk);
        #1;
        checkDrained("held start");

        // Longer compute latency on the second instance.
        pushOp(0, 1'b0, 4);
        applyStimulus(1, 1'b0);
        waitIdle(100);
        repeat (3) @(posedge clk);
        #1;
        checkDrained("lat4 op");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
